// File: rtl/k285_lane_sync.sv
// k285_lane_sync: per-lane K28.5 comma detector and LOS/ACQ/SYNC state
// machine, placed between the 8b/10b decoder and the receive framer.
// Data and K flags are passed through with one cycle of latency.
//
// Optional feature macro: K285_COMMA_STRIP_EN
//   defined   -> a comma sampled while a lane is already in SYNC is flagged
//                rx_valid=0 so downstream logic can drop idle commas.
//   undefined -> rx_valid is simply the registered enb on every lane.
//
// Handshake: enb is a symbol-valid qualifier with no back-pressure. A symbol
// is consumed on every rising edge where enb=1. With enb=0 all lane state and
// the data/K registers hold, and rx_valid/k285 read 0 on the next cycle.
module k285_lane_sync #(
  parameter int          LANES    = 4,
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int          LOCK_CNT = 4,
  parameter int          LOSS_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [8*LANES-1:0]   rx_DataE,
  input  logic [LANES-1:0]     control_dk,
  input  logic [LANES-1:0]     code_err,
  output logic [8*LANES-1:0]   rx_DataS,
  output logic [LANES-1:0]     s_control_dk,
  output logic [LANES-1:0]     rx_valid,
  output logic [LANES-1:0]     k285,
  output logic [LANES-1:0]     sync,
  output logic                 all_sync
);

  localparam int MAXC = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_CNT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  // Per-lane state and counter; kept as a struct so a checker can bind to it.
  typedef struct packed {
    state_e          state;
    logic [CW-1:0]   cnt;
  } lane_dbg_t;

  lane_dbg_t lane_q [LANES];
  lane_dbg_t lane_d [LANES];

  logic [LANES-1:0]   comma;
  logic [LANES-1:0]   err_v;
  logic [LANES-1:0]   strip;
  logic [LANES-1:0]   sync_d;
  logic [LANES-1:0]   valid_d;
  logic [CW-1:0]      cnt_inc [LANES];

  logic [8*LANES-1:0] data_q;
  logic [LANES-1:0]   dk_q;
  logic [LANES-1:0]   valid_q;
  logic [LANES-1:0]   k285_q;
  logic [LANES-1:0]   sync_q;
  logic               all_sync_q;

  // Per-lane comma qualification and LOS/ACQ/SYNC next-state selection.
  always_comb begin
    comma  = '0;
    err_v  = '0;
    strip  = '0;
    sync_d = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_d[i]  = lane_q[i];
      // A code error always wins: such a symbol is never a comma.
      comma[i]   = enb && control_dk[i] && !code_err[i] &&
                   (rx_DataE[8*i +: 8] == COMMA);
      err_v[i]   = enb && code_err[i];
      // Saturate instead of wrapping, even though the thresholds keep cnt low.
      cnt_inc[i] = (lane_q[i].cnt == '1) ? lane_q[i].cnt : lane_q[i].cnt + CNT_ONE;
      case (lane_q[i].state)
        ST_LOS: begin
          if (comma[i]) begin
            if (LOCK_CNT == 1) begin
              lane_d[i].state = ST_SYNC;
              lane_d[i].cnt   = '0;
            end else begin
              lane_d[i].state = ST_ACQ;
              lane_d[i].cnt   = CNT_ONE;
            end
          end
        end
        ST_ACQ: begin
          if (err_v[i]) begin
            lane_d[i].state = ST_LOS;
            lane_d[i].cnt   = '0;
          end else if (comma[i]) begin
            if (cnt_inc[i] == LOCK_LAST) begin
              lane_d[i].state = ST_SYNC;
              lane_d[i].cnt   = '0;
            end else begin
              lane_d[i].cnt   = cnt_inc[i];
            end
          end
        end
        ST_SYNC: begin
          if (err_v[i]) begin
            if (cnt_inc[i] == LOSS_LAST) begin
              lane_d[i].state = ST_LOS;
              lane_d[i].cnt   = '0;
            end else begin
              lane_d[i].cnt   = cnt_inc[i];
            end
          end else if (enb) begin
            // Any clean symbol breaks the consecutive-error run.
            lane_d[i].cnt = '0;
          end
        end
        default: begin
          lane_d[i].state = ST_LOS;
          lane_d[i].cnt   = '0;
        end
      endcase
`ifdef K285_COMMA_STRIP_EN
      strip[i]  = comma[i] && (lane_q[i].state == ST_SYNC);
`endif
      sync_d[i] = (lane_d[i].state == ST_SYNC);
    end
    valid_d = {LANES{enb}} & ~strip;
  end

  // Register lane state, pass-through data and all per-lane flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i].state <= ST_LOS;
        lane_q[i].cnt   <= '0;
      end
      data_q     <= '0;
      dk_q       <= '0;
      valid_q    <= '0;
      k285_q     <= '0;
      sync_q     <= '0;
      all_sync_q <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= lane_d[i];
      end
      if (enb) begin
        data_q <= rx_DataE;
        dk_q   <= control_dk;
      end
      valid_q    <= valid_d;
      k285_q     <= comma;
      sync_q     <= sync_d;
      all_sync_q <= &sync_d;
    end
  end

  assign rx_DataS     = data_q;
  assign s_control_dk = dk_q;
  assign rx_valid     = valid_q;
  assign k285         = k285_q;
  assign sync         = sync_q;
  assign all_sync     = all_sync_q;

endmodule
